// File: rtl/dcache_assoc.sv
// dcache_assoc: set-associative, write-back, write-allocate L1 data cache
// with true-LRU replacement (per-way age counters, age 0 = most recent).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset
//   p1_addr_i/p1_data_i   CPU byte address (word aligned) and store data
//   p1_MemRead_i/Write_i  load / store request (both high = store)
//   p1_data_o             load data (0 unless a read completes this cycle)
//   p1_stall_o            pipeline stall while a miss is being serviced
//   mem_data_i/mem_ack_i  refill line and one-cycle completion pulse
//   mem_data_o/mem_addr_o writeback line and line-aligned address
//   mem_enable_o          memory request, mem_write_o 1=writeback 0=refill
module dcache_assoc #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 16,
    parameter int WAYS   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam int OFF    = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF - IDX_W;
    localparam int WSEL_W = OFF - 2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AGE_W  = WAY_W;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_REFILL    = 2'd2;
    localparam logic [1:0] S_RESOLVE   = 2'd3;

    localparam logic [AGE_W-1:0] AGE_OLDEST = AGE_W'(WAYS - 1);

    logic [LINE_W-1:0] data_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [AGE_W-1:0]  age_q   [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];

    logic [1:0]       state_q;
    logic [WAY_W-1:0] victim_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] wsel;
    logic              req;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  vict;
    logic              found_invalid;
    logic [WAY_W-1:0]  access_way;
    logic              access_en;
    logic [AGE_W-1:0]  ref_age;
    logic [LINE_W-1:0] sel_line;
    logic [LINE_W-1:0] victim_line;
    logic [TAG_W-1:0]  victim_tag;
    logic              unused_addr_bits;

    assign req_tag = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign idx     = p1_addr_i[OFF +: IDX_W];
    assign wsel    = p1_addr_i[2 +: WSEL_W];
    assign req     = p1_MemRead_i | p1_MemWrite_i;
    assign unused_addr_bits = &{1'b0, p1_addr_i[1:0]};

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, else the way holding the oldest age.
    always_comb begin
        vict          = '0;
        found_invalid = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found_invalid && !valid_q[idx][w]) begin
                vict          = WAY_W'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] == AGE_OLDEST) vict = WAY_W'(w);
            end
        end
    end

    assign access_way = (state_q == S_RESOLVE) ? victim_q : hit_way;
    assign access_en  = req && ((state_q == S_IDLE && hit) || state_q == S_RESOLVE);

    // A freshly filled way is aged as if it were the oldest, so filling an
    // invalid way (whose age may still be the reset 0) ages every other way
    // and keeps the ages a permutation once the set is full.
    assign ref_age = (state_q == S_RESOLVE) ? AGE_OLDEST : age_q[idx][hit_way];

    assign sel_line    = data_q[idx][access_way];
    assign victim_line = data_q[idx][victim_q];
    assign victim_tag  = tag_q[idx][victim_q];

    always_comb begin
        p1_data_o    = '0;
        p1_stall_o   = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        if (access_en && !p1_MemWrite_i) p1_data_o = sel_line[wsel*WORD_W +: WORD_W];
        case (state_q)
            S_IDLE: p1_stall_o = req && !hit;
            S_WRITEBACK: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {victim_tag, idx, {OFF{1'b0}}};
                mem_data_o   = victim_line;
            end
            S_REFILL: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, idx, {OFF{1'b0}}};
            end
            default: ;
        endcase
    end

    // Line data and tags carry no reset; validity is tracked separately.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (state_q == S_REFILL && mem_ack_i) begin
                data_q[idx][victim_q] <= mem_data_i;
                tag_q[idx][victim_q]  <= req_tag;
            end else if (access_en && p1_MemWrite_i) begin
                data_q[idx][access_way][wsel*WORD_W +: WORD_W] <= p1_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            victim_q <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) age_q[s][w] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req && !hit) begin
                        victim_q <= vict;
                        state_q  <= dirty_q[idx][vict] ? S_WRITEBACK : S_REFILL;
                    end
                end
                S_WRITEBACK: if (mem_ack_i) state_q <= S_REFILL;
                S_REFILL: begin
                    if (mem_ack_i) begin
                        valid_q[idx][victim_q] <= 1'b1;
                        dirty_q[idx][victim_q] <= 1'b0;
                        state_q                <= S_RESOLVE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (access_en) begin
                if (p1_MemWrite_i) dirty_q[idx][access_way] <= 1'b1;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == access_way)
                        age_q[idx][w] <= '0;
                    else if (age_q[idx][w] < ref_age)
                        age_q[idx][w] <= age_q[idx][w] + 1'b1;
                end
            end
        end
    end

endmodule
